// File: rtl/param_reg_file_pkg.sv
// rtl/param_reg_file_pkg.sv - shared defaults, address type and sizing helper for param_reg_file
package param_reg_file_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_NUM_RD = 2;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

    // Number of architectural registers addressed by an addr_w-bit index.
    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// rtl/param_reg_file_if.sv - write, reserve, read and status signals of param_reg_file
interface param_reg_file_if
    import param_reg_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = DEFAULT_NUM_RD
) ();

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD-1:0]        rd_busy;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_busy, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_en, rd_addr,
        output rd_data, rd_valid, rd_busy, busy_cnt
    );

endinterface

// File: rtl/param_reg_file_scoreboard.sv
// rtl/param_reg_file_scoreboard.sv - per-register busy bits and count of pending write-backs
module regfile_scoreboard
    import param_reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]        busy_cnt
);

    logic                   rsv_ok;
    logic                   wr_ok;
    logic                   set_inc;
    logic                   clr_dec;
    logic [(2**ADDR_W)-1:0] busy_d;
    logic [ADDR_W:0]        cnt_d;

    // Register 0 is hard-wired when ZERO_REG is set, so it never takes a reservation or a clear.
    always_comb begin
        rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
        wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    end

    // Next busy vector: the write-back clears first, a reservation to the same register re-sets it.
    always_comb begin
        busy_d = busy;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // The count moves only on real 0->1 and 1->0 transitions, so it cannot overflow or underflow.
    always_comb begin
        set_inc = rsv_ok && !busy[rsv_addr];
        clr_dec = wr_ok && busy[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
        cnt_d   = busy_cnt + (ADDR_W+1)'(set_inc) - (ADDR_W+1)'(clr_dec);
    end

    // Busy state and its population count update together on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - multi-read-port register file with reservation scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    param_reg_file_if.slave bus
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [ADDR_W:0]          busy_cnt;
    logic                     wr_ok;

    logic [ADDR_W-1:0]        rd_addr_a  [NUM_RD];
    logic [DATA_W-1:0]        rd_val     [NUM_RD];
    logic [NUM_RD-1:0]        rd_bsy_val;

    logic [DATA_W-1:0]        rd_data_q  [NUM_RD];
    logic [NUM_RD-1:0]        rd_busy_q;
    logic [NUM_RD-1:0]        rd_valid_q;
    logic [NUM_RD*DATA_W-1:0] rd_data_pk;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // A write to the hard-wired zero register is dropped before it reaches the array.
    always_comb begin
        wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
    end

    // Data array: writes are never stalled by reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Unpack the per-port read addresses.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_a[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
        end
    end

    // Per-port read lookup, with optional forwarding of a same-cycle write and zero-register override.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val[p]     = regs_q[rd_addr_a[p]];
            rd_bsy_val[p] = busy[rd_addr_a[p]];
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_en && (bus.wr_addr == rd_addr_a[p])) begin
                rd_val[p]     = bus.wr_data;
                rd_bsy_val[p] = bus.rsv_en && (bus.rsv_addr == rd_addr_a[p]);
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr_a[p] == '0)) begin
                rd_val[p]     = '0;
                rd_bsy_val[p] = 1'b0;
            end
        end
    end

    // Read ports: capture on rd_en, hold otherwise; rd_valid pulses the cycle after a sampled strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p] <= '0;
            end
            rd_busy_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.rd_en[p]) begin
                    rd_data_q[p] <= rd_val[p];
                    rd_busy_q[p] <= rd_bsy_val[p];
                end
            end
        end
    end

    // Pack the per-port read data onto the bus.
    always_comb begin
        rd_data_pk = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_pk[p*DATA_W +: DATA_W] = rd_data_q[p];
        end
    end

    assign bus.rd_data  = rd_data_pk;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_cnt = busy_cnt;

endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - directed and randomized checks of param_reg_file against a behavioural model
module tb_param_reg_file;
    import param_reg_file_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    param_reg_file #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int mem       [DEPTH];
    bit mbusy     [DEPTH];
    int exp_data  [NR];
    bit exp_busy  [NR];
    bit exp_valid [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = 0;
            mbusy[i] = 1'b0;
        end
        for (int p = 0; p < NR; p++) begin
            exp_data[p]  = 0;
            exp_busy[p]  = 1'b0;
            exp_valid[p] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NR; p++) begin
            check($sformatf("%s.valid%0d", tag, p), 32'(bus.rd_valid[p]), 32'(exp_valid[p]));
            check($sformatf("%s.data%0d", tag, p), 32'(bus.rd_data[p*DW +: DW]), 32'(exp_data[p]));
            check($sformatf("%s.busy%0d", tag, p), 32'(bus.rd_busy[p]), 32'(exp_busy[p]));
        end
        check($sformatf("%s.cnt", tag), 32'(bus.busy_cnt), 32'(model_cnt()));
    endtask

    task automatic drive_idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
    endtask

    // One clock: drive, predict from the pre-edge model, take the edge, update the model, compare.
    task automatic cycle(input string tag, input bit we, input int wa, input int wd,
                         input bit rv, input int ra, input bit [1:0] re, input int a0, input int a1);
        int addr [NR];
        int nd   [NR];
        bit nb   [NR];
        addr[0] = a0;
        addr[1] = a1;
        bus.wr_en    = we;
        bus.wr_addr  = AW'(wa);
        bus.wr_data  = DW'(wd);
        bus.rsv_en   = rv;
        bus.rsv_addr = AW'(ra);
        bus.rd_en    = re;
        bus.rd_addr  = {AW'(a1), AW'(a0)};
        for (int p = 0; p < NR; p++) begin
            if (addr[p] == 0) begin
                nd[p] = 0;
                nb[p] = 1'b0;
            end else if (BYP && we && wa == addr[p]) begin
                nd[p] = wd;
                nb[p] = rv && (ra == addr[p]);
            end else begin
                nd[p] = mem[addr[p]];
                nb[p] = mbusy[addr[p]];
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NR; p++) begin
            exp_valid[p] = re[p];
            if (re[p]) begin
                exp_data[p] = nd[p];
                exp_busy[p] = nb[p];
            end
        end
        if (we && wa != 0) begin
            mem[wa]   = wd;
            mbusy[wa] = 1'b0;
        end
        if (rv && ra != 0) mbusy[ra] = 1'b1;
        check_outputs(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".cnt0"}, 32'(bus.busy_cnt), 32'd0);
        check({tag, ".valid0"}, 32'(bus.rd_valid), 32'd0);
        check({tag, ".data0"}, 32'(bus.rd_data), 32'd0);
        check({tag, ".busy0"}, 32'(bus.rd_busy), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, DEPTH-1));
    endfunction

    initial begin
        reg_addr_t ra_t;
        drive_idle();
        model_reset();
        rst = 1'b1;
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        cycle("r035", 0, 0, 0, 0, 0, 2'b11, 3, 31);
        check("r035.d0", 32'(bus.rd_data[15:0]), 32'h0);
        check("r035.d1", 32'(bus.rd_data[31:16]), 32'h0);
        check("r035.v", 32'(bus.rd_valid), 32'h3);
        cycle("r035.idle", 0, 0, 0, 0, 0, 2'b00, 0, 0);

        cycle("r036.wr", 1, 7, 'hBEEF, 0, 0, 2'b00, 0, 0);
        cycle("r036.rd", 0, 0, 0, 0, 0, 2'b11, 7, 7);
        check("r036.d0", 32'(bus.rd_data[15:0]), 32'hBEEF);
        check("r036.d1", 32'(bus.rd_data[31:16]), 32'hBEEF);

        cycle("r037.wrrd", 1, 5, 'h1234, 0, 0, 2'b01, 5, 0);
        check("r037.byp", 32'(bus.rd_data[15:0]), BYP ? 32'h1234 : 32'h0);
        cycle("r037.rd", 0, 0, 0, 0, 0, 2'b01, 5, 0);
        check("r037.after", 32'(bus.rd_data[15:0]), 32'h1234);

        cycle("r038.rsv2", 0, 0, 0, 1, 2, 2'b00, 0, 0);
        cycle("r038.rsv9", 0, 0, 0, 1, 9, 2'b00, 0, 0);
        cycle("r038.rsv2b", 0, 0, 0, 1, 2, 2'b00, 0, 0);
        check("r038.cnt2", 32'(bus.busy_cnt), 32'd2);
        cycle("r038.rd9", 0, 0, 0, 0, 0, 2'b01, 9, 0);
        check("r038.busy9", 32'(bus.rd_busy[0]), 32'd1);
        cycle("r038.wr9", 1, 9, 'h0099, 0, 0, 2'b00, 0, 0);
        check("r038.cnt1", 32'(bus.busy_cnt), 32'd1);
        cycle("r038.rsvwr2", 1, 2, 'h0022, 1, 2, 2'b00, 0, 0);
        check("r038.cnt1b", 32'(bus.busy_cnt), 32'd1);
        cycle("r038.rd2", 0, 0, 0, 0, 0, 2'b10, 0, 2);
        check("r038.busy2", 32'(bus.rd_busy[1]), 32'd1);
        check("r038.data2", 32'(bus.rd_data[31:16]), 32'h0022);

        cycle("r039.wr0", 1, 0, 'hFFFF, 1, 0, 2'b00, 0, 0);
        cycle("r039.rd0", 0, 0, 0, 0, 0, 2'b11, 0, 0);
        check("r039.d0", 32'(bus.rd_data), 32'h0);
        check("r039.busy", 32'(bus.rd_busy), 32'h0);
        check("r039.cnt", 32'(bus.busy_cnt), 32'd1);

        cycle("r040.wr4", 1, 4, 'hAAAA, 1, 4, 2'b00, 0, 0);
        cycle("r040.rd4", 0, 0, 0, 0, 0, 2'b01, 4, 0);
        check("r040.pre", 32'(bus.rd_data[15:0]), 32'hAAAA);
        async_reset("r040.rst");
        cycle("r040.idle", 0, 0, 0, 0, 0, 2'b00, 0, 0);
        ra_t = 5'd4;
        cycle("r040.rd4b", 0, 0, 0, 0, 0, 2'b01, int'(ra_t), 0);
        check("r040.post", 32'(bus.rd_data[15:0]), 32'h0);
        check("r040.cnt", 32'(bus.busy_cnt), 32'd0);

        for (int i = 0; i < 500; i++) begin
            bit       we;
            bit       rv;
            bit [1:0] re;
            we = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 2) == 0);
            re = 2'($urandom_range(0, 3));
            cycle($sformatf("rnd%0d", i), we, rand_addr(), int'($urandom_range(0, 16'hFFFF)),
                  rv, rand_addr(), re, rand_addr(), rand_addr());
            if (i % 170 == 169) async_reset($sformatf("rnd%0d.rst", i));
        end

        drive_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes and reservations.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  ADDR_W  write destination.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 rsv_en  input  1  reserve strobe; marks a destination busy (pending write-back).
REQ-011 rsv_addr  input  ADDR_W  register to reserve.
REQ-012 rd_en  input  NUM_RD  per-port read strobe.
REQ-013 rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port p at bits [p*ADDR_W +: ADDR_W].
REQ-014 rd_data  output  NUM_RD*DATA_W  packed registered read data.
REQ-015 rd_valid  output  NUM_RD  per-port pulse, high the cycle after a sampled rd_en.
REQ-016 rd_busy  output  NUM_RD  per-port busy flag of the read register, registered with rd_data.
REQ-017 busy_cnt  output  ADDR_W+1  count of currently reserved registers.

Function
REQ-018 Write SHALL update the array at the rising edge where wr_en=1; it is never blocked by reads (reads and writes are concurrent).
REQ-019 Each read port SHALL capture array[rd_addr] at the edge where its rd_en=1: latency 1 cycle, rd_valid high exactly that next cycle.
REQ-020 rd_data and rd_busy of a port SHALL hold their last values while its rd_en=0.
REQ-021 Any number of ports SHALL read the same address in one cycle with identical results.
REQ-022 rsv_en SHALL set busy[rsv_addr]; wr_en SHALL clear busy[wr_addr]; busy_cnt SHALL track the number of set bits, updated in the same edge.
REQ-023 rsv_en and wr_en to the same address in one cycle: reservation wins, busy stays/ends set, data written.
REQ-024 rsv_en on an already-busy register SHALL leave busy_cnt unchanged; wr_en on a non-busy register SHALL write data and leave busy_cnt unchanged.
REQ-025 With ZERO_REG=1: writes and reservations to address 0 SHALL be ignored; reads of address 0 SHALL return 0 with rd_busy=0.
REQ-026 busy_cnt SHALL never exceed DEPTH (DEPTH-1 with ZERO_REG=1) nor underflow.

Reset
REQ-027 While rst=1 all registers SHALL be 0, all busy bits 0, busy_cnt 0, rd_data 0, rd_valid 0, rd_busy 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard in-flight reads (rd_valid 0 the following cycle) and all reservations.
REQ-029 No register SHALL hold a non-zero preset value after reset.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 Defined: a read sampled in the same cycle as a write to the same address SHALL return wr_data and rd_busy=0 (unless rsv_en to it also present, then 1).
REQ-032 Undefined: such a read SHALL return the pre-write value and the pre-write busy bit.

Structure
REQ-033 A shared package SHALL hold default DATA_W/ADDR_W/NUM_RD constants and the register-address typedef.
REQ-034 One sub-module, regfile_scoreboard (busy bits plus busy_cnt), SHALL be separated out; the data array and read ports stay in param_reg_file.

Verification
REQ-035 Reset then read addr 3 and 31 on both ports -> rd_data 0x0000, rd_valid pulses one cycle later, busy_cnt 0.
REQ-036 Write 0xBEEF to r7, next cycle read r7 on port 0 and r7 on port 1 -> both 0xBEEF one cycle later.
REQ-037 Same-cycle write 0x1234 to r5 and read r5 (old 0x0000) -> 0x1234 with REGFILE_BYPASS_EN, 0x0000 without.
REQ-038 Reserve r2, r9, r2 -> busy_cnt 2; read r9 -> rd_busy 1; write r9 -> busy_cnt 1; same-cycle rsv+write r2 -> busy_cnt 1, r2 busy.
REQ-039 ZERO_REG=1: write 0xFFFF and reserve r0 -> read r0 gives 0x0000, rd_busy 0, busy_cnt unchanged.
REQ-040 Write r4 0xAAAA, reserve r4, assert rst asynchronously between edges -> outputs 0 immediately, r4 reads 0x0000, busy_cnt 0 after release.
